imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boots instruction memory from a serial byte stream.
// Stream format: LEN_HI, LEN_LO, then N x {B0, B1, B2}, then an XOR checksum.
// The CPU is stalled while a load is in progress; otherwise its fetch port
// passes straight through to the instruction memory.
module imem_loader #(
   parameter int DEPTH  = 8192,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_req,
   input  logic [7:0]        rx_data,
   input  logic              rx_vld,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rd_en,
   output logic [ADDR_W-1:0] im_addr,
   output logic              im_rd_en,
   output logic              im_wr_en,
   output logic [16:0]       im_wr_data,
   output logic              cpu_stall,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LEN_HI = 4'd1,
      LEN_LO = 4'd2,
      B0     = 4'd3,
      B1     = 4'd4,
      B2     = 4'd5,
      CHK    = 4'd6,
      DONE   = 4'd7,
      ERR    = 4'd8
   } state_t;

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   state_t              state_q;
   logic                boot_q;
   logic [7:0]          len_hi_q;
   logic [15:0]         len_q;
   logic [8:0]          asm_q;      // {instr[16], instr[15:8]} under assembly
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [7:0]          csum_q;
   logic                wr_en_q;
   logic [16:0]         wr_data_q;  // separate from asm_q so the next B0 can land during the write
   logic                done_q;
   logic                err_q;

   logic                boot_rise_s;
   logic [15:0]         len_s;
   logic                len_bad_s;
   logic                last_instr_s;
   logic                loading_s;

   assign boot_rise_s  = boot_req & ~boot_q;
   assign len_s        = {len_hi_q, rx_data};
   assign len_bad_s    = (len_s == 16'd0) || ({16'd0, len_s} > DEPTH_U);
   // At a B2 byte the previous write has already retired, so wr_ptr_q counts
   // completed instructions and this one is the last when wr_ptr_q+1 == N.
   assign last_instr_s = ((32'(wr_ptr_q) + 32'd1) == {16'd0, len_q});
   assign loading_s    = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);

   // Loader FSM together with its datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         boot_q    <= 1'b0;
         len_hi_q  <= 8'd0;
         len_q     <= 16'd0;
         asm_q     <= 9'd0;
         wr_ptr_q  <= '0;
         csum_q    <= 8'd0;
         wr_en_q   <= 1'b0;
         wr_data_q <= 17'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         boot_q  <= boot_req;
         wr_en_q <= 1'b0;
         if (wr_en_q) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         end
         case (state_q)
            IDLE, DONE, ERR: begin
               if (boot_rise_s) begin
                  state_q  <= LEN_HI;
                  done_q   <= 1'b0;
                  err_q    <= 1'b0;
                  wr_ptr_q <= '0;
                  csum_q   <= 8'd0;
               end
            end
            LEN_HI: begin
               if (rx_vld) begin
                  len_hi_q <= rx_data;
                  csum_q   <= csum_q ^ rx_data;
                  state_q  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (rx_vld) begin
                  len_q  <= len_s;
                  csum_q <= csum_q ^ rx_data;
                  if (len_bad_s) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= B0;
                  end
               end
            end
            B0: begin
               if (rx_vld) begin
                  asm_q[8] <= rx_data[0];
                  csum_q   <= csum_q ^ rx_data;
                  state_q  <= B1;
               end
            end
            B1: begin
               if (rx_vld) begin
                  asm_q[7:0] <= rx_data;
                  csum_q     <= csum_q ^ rx_data;
                  state_q    <= B2;
               end
            end
            B2: begin
               if (rx_vld) begin
                  wr_data_q <= {asm_q, rx_data};
                  wr_en_q   <= 1'b1;
                  csum_q    <= csum_q ^ rx_data;
                  state_q   <= last_instr_s ? CHK : B0;
               end
            end
            CHK: begin
               if (rx_vld) begin
                  if (rx_data == csum_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Memory port mux: loader owns the address while loading, CPU otherwise.
   always_comb begin
      im_addr  = cpu_addr;
      im_rd_en = cpu_rd_en;
      if (loading_s) begin
         im_addr  = wr_ptr_q;
         im_rd_en = 1'b0;
      end else begin
         im_addr  = cpu_addr;
         im_rd_en = cpu_rd_en;
      end
   end

   assign im_wr_en   = wr_en_q;
   assign im_wr_data = wr_data_q;
   assign cpu_stall  = loading_s;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every im_wr_en pulse.
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        boot_req;
   logic [7:0]  rx_data;
   logic        rx_vld;
   logic [15:0] cpu_addr;
   logic        cpu_rd_en;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic        im_wr_en;
   logic [16:0] im_wr_data;
   logic        cpu_stall;
   logic        load_done;
   logic        load_err;

   int errors = 0;
   int checks = 0;

   logic [32:0] exp_q[$];   // {addr[15:0], data[16:0]}
   logic [7:0]  tx_q[$];

   imem_loader #(.DEPTH(8192), .ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .boot_req(boot_req),
      .rx_data(rx_data), .rx_vld(rx_vld),
      .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en),
      .im_addr(im_addr), .im_rd_en(im_rd_en), .im_wr_en(im_wr_en),
      .im_wr_data(im_wr_data), .cpu_stall(cpu_stall),
      .load_done(load_done), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (im_wr_en === 1'b1) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", im_addr, im_wr_data);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({im_addr, im_wr_data} !== e) begin
               errors = errors + 1;
               $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                        im_addr, im_wr_data, e[32:17], e[16:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [16:0] d);
      exp_q.push_back({a, d});
   endtask

   // Send every queued byte, with 'gap' idle cycles between bytes.
   task automatic send_all(input int gap);
      while (tx_q.size() != 0) begin
         rx_data = tx_q.pop_front();
         rx_vld  = 1'b1;
         step();
         rx_vld  = 1'b0;
         repeat (gap) step();
      end
      rx_data = 8'h00;
   endtask

   task automatic boot(input logic hold);
      boot_req = 1'b1;
      step();
      boot_req = hold;
   endtask

   task automatic push_bytes(input logic [7:0] b[]);
      foreach (b[i]) tx_q.push_back(b[i]);
   endtask

   initial begin
      rst_n     = 1'b0;
      boot_req  = 1'b0;
      rx_data   = 8'h00;
      rx_vld    = 1'b0;
      cpu_addr  = 16'h0123;
      cpu_rd_en = 1'b1;
      step();
      step();
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_err", 32'(load_err), 32'd0);
      chk("rst_wr_en", 32'(im_wr_en), 32'd0);
      chk("rst_wr_data", 32'(im_wr_data), 32'd0);
      chk("idle_addr", 32'(im_addr), 32'h0123);
      chk("idle_rd_en", 32'(im_rd_en), 32'd1);
      rst_n = 1'b1;
      step();

      // Two instructions with idle gaps; XOR of 00 02 01 12 34 00 AB CD is 0x43.
      boot(1'b0);
      push_bytes('{8'h00, 8'h02});
      send_all(2);
      chk("load_stall", 32'(cpu_stall), 32'd1);
      chk("load_rd_en", 32'(im_rd_en), 32'd0);
      chk("load_addr", 32'(im_addr), 32'h0000);
      expect_wr(16'h0000, 17'h11234);
      expect_wr(16'h0001, 17'h0ABCD);
      push_bytes('{8'h01, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD, 8'h43});
      send_all(2);
      chk("good_done", 32'(load_done), 32'd1);
      chk("good_err", 32'(load_err), 32'd0);
      chk("good_stall", 32'(cpu_stall), 32'd0);
      chk("good_rd_en", 32'(im_rd_en), 32'd1);

      // Same stream, wrong checksum: writes still happen, then error.
      boot(1'b0);
      expect_wr(16'h0000, 17'h11234);
      expect_wr(16'h0001, 17'h0ABCD);
      push_bytes('{8'h00, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'hAB, 8'hCD, 8'h7C});
      send_all(1);
      chk("badcs_err", 32'(load_err), 32'd1);
      chk("badcs_done", 32'(load_done), 32'd0);
      chk("badcs_stall", 32'(cpu_stall), 32'd0);

      // Zero length: error right after LEN_LO, no writes.
      boot(1'b0);
      push_bytes('{8'h00, 8'h00});
      send_all(0);
      chk("len0_err", 32'(load_err), 32'd1);
      chk("len0_stall", 32'(cpu_stall), 32'd0);

      // Length 8193 exceeds DEPTH.
      boot(1'b0);
      push_bytes('{8'h20, 8'h01});
      send_all(0);
      chk("lenbig_err", 32'(load_err), 32'd1);
      chk("lenbig_done", 32'(load_done), 32'd0);
      repeat (3) step();

      // Back-to-back N=3; B0 upper bits ignored (FE -> bit16=0). Checksum 0x02.
      boot(1'b0);
      expect_wr(16'h0000, 17'h1FFFF);
      expect_wr(16'h0001, 17'h00001);
      expect_wr(16'h0002, 17'h15A5A);
      push_bytes('{8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h01,
                   8'h01, 8'h5A, 8'h5A, 8'h02});
      send_all(0);
      chk("b2b_done", 32'(load_done), 32'd1);
      chk("b2b_err", 32'(load_err), 32'd0);
      chk("b2b_pending", 32'(exp_q.size()), 32'd0);

      // boot_req held high through and after a load: no restart.
      boot(1'b1);
      expect_wr(16'h0000, 17'h00007);
      push_bytes('{8'h00, 8'h01, 8'h00, 8'h00, 8'h07, 8'h06});
      send_all(0);
      repeat (3) step();
      chk("hold_done", 32'(load_done), 32'd1);
      chk("hold_stall", 32'(cpu_stall), 32'd0);
      boot_req = 1'b0;
      step();
      boot_req = 1'b1;
      step();
      chk("reboot_done_clr", 32'(load_done), 32'd0);
      chk("reboot_stall", 32'(cpu_stall), 32'd1);
      boot_req = 1'b0;
      expect_wr(16'h0000, 17'h1FFFF);
      push_bytes('{8'h00, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00});
      send_all(0);
      chk("reboot_done", 32'(load_done), 32'd1);

      // Reset while sitting in B1 of the first instruction.
      boot(1'b0);
      push_bytes('{8'h00, 8'h02, 8'h01});
      send_all(0);
      chk("midload_stall", 32'(cpu_stall), 32'd1);
      cpu_addr  = 16'h0042;
      cpu_rd_en = 1'b1;
      rst_n     = 1'b0;
      step();
      chk("midrst_stall", 32'(cpu_stall), 32'd0);
      chk("midrst_addr", 32'(im_addr), 32'h0042);
      chk("midrst_rd_en", 32'(im_rd_en), 32'd1);
      chk("midrst_wr_en", 32'(im_wr_en), 32'd0);
      chk("midrst_done", 32'(load_done), 32'd0);
      cpu_rd_en = 1'b0;
      step();
      chk("midrst_rd_off", 32'(im_rd_en), 32'd0);
      rst_n = 1'b1;
      repeat (2) step();

      chk("final_pending", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
